// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared master IDs, bus field widths and request bundle for bus_arbiter_rr2.
// Revision: 1.0
`default_nettype none

package bus_arb_pkg;

  localparam int ID_W   = 1;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef logic [ID_W-1:0] mid_t;

  localparam mid_t M0_ID = 1'b0;
  localparam mid_t M1_ID = 1'b1;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

endpackage

`default_nettype wire

// File: rtl/arb_id_fifo.sv
// arb_id_fifo: in-order FIFO of master IDs for outstanding reads; push/pop may coincide.
// Revision: 1.0
`default_nettype none

module arb_id_fifo
  import bus_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push,
  input  logic pop,
  input  mid_t din,
  output mid_t dout,
  output logic full,
  output logic empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  mid_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/bus_arbiter_rr2.sv
// bus_arbiter_rr2: two-master round-robin (or fixed) arbiter with in-order read response routing.
// Revision: 1.0
`default_nettype none

module bus_arbiter_rr2
  import bus_arb_pkg::*;
#(
  parameter int FIXED_PRIO      = 0,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_bi,
  input  logic [BE_W-1:0]   m0_be_bi,
  input  logic [DATA_W-1:0] m0_wdata_bi,
  output logic              m0_ack_o,
  output logic              m0_resp_o,
  output logic [DATA_W-1:0] m0_rdata_bo,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_bi,
  input  logic [BE_W-1:0]   m1_be_bi,
  input  logic [DATA_W-1:0] m1_wdata_bi,
  output logic              m1_ack_o,
  output logic              m1_resp_o,
  output logic [DATA_W-1:0] m1_rdata_bo,
  output logic              s_req_o,
  output logic              s_we_o,
  output logic [ADDR_W-1:0] s_addr_bo,
  output logic [BE_W-1:0]   s_be_bo,
  output logic [DATA_W-1:0] s_wdata_bo,
  input  logic              s_ack_i,
  input  logic              s_resp_i,
  input  logic [DATA_W-1:0] s_rdata_bi,
  output logic              err_o
);

  bus_req_t m0_bus;
  bus_req_t m1_bus;
  bus_req_t gnt_bus;
  bus_req_t slave_bus;

  mid_t prio;
  logic err;

  mid_t pick_id;
  logic pick_valid;
  logic pick_we;
  logic other_req;
  logic other_we;
  mid_t gnt_id;
  logic gnt_valid;

  logic accept;
  logic fifo_push;
  logic fifo_pop;
  logic fifo_full;
  logic fifo_empty;
  mid_t fifo_head;

  assign m0_bus = '{we: m0_we_i, addr: m0_addr_bi, be: m0_be_bi, wdata: m0_wdata_bi};
  assign m1_bus = '{we: m1_we_i, addr: m1_addr_bi, be: m1_be_bi, wdata: m1_wdata_bi};

  // A read that cannot be tracked yields to the other master's write, else nothing is issued.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = M0_ID;
    if (m0_req_i && m1_req_i) begin
      pick_valid = 1'b1;
      pick_id    = (FIXED_PRIO != 0) ? M0_ID : prio;
    end else if (m0_req_i) begin
      pick_valid = 1'b1;
      pick_id    = M0_ID;
    end else if (m1_req_i) begin
      pick_valid = 1'b1;
      pick_id    = M1_ID;
    end

    pick_we   = (pick_id == M1_ID) ? m1_we_i  : m0_we_i;
    other_req = (pick_id == M1_ID) ? m0_req_i : m1_req_i;
    other_we  = (pick_id == M1_ID) ? m0_we_i  : m1_we_i;

    gnt_valid = pick_valid;
    gnt_id    = pick_id;
    if (pick_valid && !pick_we && fifo_full) begin
      if (other_req && other_we) begin
        gnt_id = ~pick_id;
      end else begin
        gnt_valid = 1'b0;
      end
    end
    if (rst_i) begin
      gnt_valid = 1'b0;
    end
  end

  assign gnt_bus   = (gnt_id == M1_ID) ? m1_bus : m0_bus;
  assign slave_bus = gnt_valid ? gnt_bus : '0;

  assign s_req_o    = gnt_valid;
  assign s_we_o     = slave_bus.we;
  assign s_addr_bo  = slave_bus.addr;
  assign s_be_bo    = slave_bus.be;
  assign s_wdata_bo = slave_bus.wdata;

  assign accept   = gnt_valid & s_ack_i;
  assign m0_ack_o = accept & (gnt_id == M0_ID);
  assign m1_ack_o = accept & (gnt_id == M1_ID);

  assign fifo_push = accept & ~gnt_bus.we;
  assign fifo_pop  = s_resp_i & ~fifo_empty & ~rst_i;

  assign m0_resp_o   = fifo_pop & (fifo_head == M0_ID);
  assign m1_resp_o   = fifo_pop & (fifo_head == M1_ID);
  assign m0_rdata_bo = m0_resp_o ? s_rdata_bi : '0;
  assign m1_rdata_bo = m1_resp_o ? s_rdata_bi : '0;

  assign err_o = err & ~rst_i;

  arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (gnt_id),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio <= M0_ID;
      err  <= 1'b0;
    end else begin
      if (accept) begin
        prio <= ~gnt_id;
      end
      if (s_resp_i && fifo_empty) begin
        err <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter_rr2.sv
// tb_bus_arbiter_rr2: directed + randomized checks of two arbiter configurations against a queue-based model.
// Revision: 1.0
`default_nettype none

module tb_bus_arbiter_rr2;

  logic        clk;
  logic        rst;
  logic        m_req   [2];
  logic        m_we    [2];
  logic [31:0] m_addr  [2];
  logic [3:0]  m_be    [2];
  logic [31:0] m_wdata [2];
  logic        s_ack;
  logic        s_resp;
  logic [31:0] s_rdata;

  logic        s_req   [2];
  logic        s_we    [2];
  logic [31:0] s_addr  [2];
  logic [3:0]  s_be    [2];
  logic [31:0] s_wdata [2];
  logic        m_ack   [2][2];
  logic        m_resp  [2][2];
  logic [31:0] m_rdata [2][2];
  logic        err     [2];

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Model: per-instance arbitration parameters, pointer, sticky error and queue of read owners.
  int fixp    [2] = '{0, 1};
  int depth_p [2] = '{4, 2};
  bit prio_m  [2];
  bit err_m   [2];
  bit mq      [2][$];
  bit exp_ack0 [2];

  bus_arbiter_rr2 #(.FIXED_PRIO(0), .MAX_OUTSTANDING(4)) u_dut_rr (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m_req[0]), .m0_we_i(m_we[0]), .m0_addr_bi(m_addr[0]), .m0_be_bi(m_be[0]),
    .m0_wdata_bi(m_wdata[0]), .m0_ack_o(m_ack[0][0]), .m0_resp_o(m_resp[0][0]), .m0_rdata_bo(m_rdata[0][0]),
    .m1_req_i(m_req[1]), .m1_we_i(m_we[1]), .m1_addr_bi(m_addr[1]), .m1_be_bi(m_be[1]),
    .m1_wdata_bi(m_wdata[1]), .m1_ack_o(m_ack[0][1]), .m1_resp_o(m_resp[0][1]), .m1_rdata_bo(m_rdata[0][1]),
    .s_req_o(s_req[0]), .s_we_o(s_we[0]), .s_addr_bo(s_addr[0]), .s_be_bo(s_be[0]), .s_wdata_bo(s_wdata[0]),
    .s_ack_i(s_ack), .s_resp_i(s_resp), .s_rdata_bi(s_rdata), .err_o(err[0])
  );

  bus_arbiter_rr2 #(.FIXED_PRIO(1), .MAX_OUTSTANDING(2)) u_dut_fix (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m_req[0]), .m0_we_i(m_we[0]), .m0_addr_bi(m_addr[0]), .m0_be_bi(m_be[0]),
    .m0_wdata_bi(m_wdata[0]), .m0_ack_o(m_ack[1][0]), .m0_resp_o(m_resp[1][0]), .m0_rdata_bo(m_rdata[1][0]),
    .m1_req_i(m_req[1]), .m1_we_i(m_we[1]), .m1_addr_bi(m_addr[1]), .m1_be_bi(m_be[1]),
    .m1_wdata_bi(m_wdata[1]), .m1_ack_o(m_ack[1][1]), .m1_resp_o(m_resp[1][1]), .m1_rdata_bo(m_rdata[1][1]),
    .s_req_o(s_req[1]), .s_we_o(s_we[1]), .s_addr_bo(s_addr[1]), .s_be_bo(s_be[1]), .s_wdata_bo(s_wdata[1]),
    .s_ack_i(s_ack), .s_resp_i(s_resp), .s_rdata_bi(s_rdata), .err_o(err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Compare every output of both instances with the model, then advance the model across the clock edge.
  task automatic tick();
    #2;
    for (int k = 0; k < 2; k++) begin
      bit          has;
      int          w;
      bit [68:0]   ef;
      bit          ea [2];
      bit          er [2];
      bit [31:0]   ed [2];
      bit          hv;
      bit          hd;
      has = 1'b0;
      w   = 0;
      hv  = 1'b0;
      hd  = 1'b0;
      if (!rst) begin
        if (m_req[0] && m_req[1]) begin
          has = 1'b1;
          w   = (fixp[k] != 0) ? 0 : int'(prio_m[k]);
        end else if (m_req[0] || m_req[1]) begin
          has = 1'b1;
          w   = m_req[0] ? 0 : 1;
        end
        if (has && !m_we[w] && mq[k].size() == depth_p[k]) begin
          if (m_req[1-w] && m_we[1-w]) w = 1 - w;
          else has = 1'b0;
        end
        hv = s_resp && (mq[k].size() > 0);
        if (hv) hd = mq[k][0];
      end
      ef = has ? {m_we[w], m_addr[w], m_be[w], m_wdata[w]} : '0;
      for (int i = 0; i < 2; i++) begin
        ea[i] = has && (w == i) && s_ack;
        er[i] = hv && (int'(hd) == i);
        ed[i] = er[i] ? s_rdata : 32'h0;
      end
      check_val($sformatf("k%0d s_req", k), s_req[k], has);
      check_val($sformatf("k%0d s_fields", k), {s_we[k], s_addr[k], s_be[k], s_wdata[k]}, ef);
      for (int i = 0; i < 2; i++) begin
        check_val($sformatf("k%0d m%0d_ack", k, i), m_ack[k][i], ea[i]);
        check_val($sformatf("k%0d m%0d_resp", k, i), m_resp[k][i], er[i]);
        check_val($sformatf("k%0d m%0d_rdata", k, i), m_rdata[k][i], ed[i]);
      end
      check_val($sformatf("k%0d err", k), err[k], rst ? 1'b0 : err_m[k]);

      if (k == 0) begin
        exp_ack0[0] = ea[0];
        exp_ack0[1] = ea[1];
      end
      if (rst) begin
        mq[k].delete();
        prio_m[k] = 1'b0;
        err_m[k]  = 1'b0;
      end else begin
        if (hv) void'(mq[k].pop_front());
        else if (s_resp) err_m[k] = 1'b1;
        if (has && s_ack) begin
          if (!m_we[w]) mq[k].push_back(w[0]);
          prio_m[k] = (w == 0);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    for (int i = 0; i < 2; i++) begin
      m_req[i] = 1'b0; m_we[i] = 1'b0; m_addr[i] = '0; m_be[i] = '0; m_wdata[i] = '0;
    end
    s_ack = 1'b0; s_resp = 1'b0; s_rdata = '0; rst = 1'b0;
  endtask

  task automatic set_m(input int i, input bit req, input bit we, input logic [31:0] addr);
    m_req[i] = req; m_we[i] = we; m_addr[i] = addr; m_be[i] = 4'hF; m_wdata[i] = addr ^ 32'h5A5A_0000;
  endtask

  task automatic resp(input logic [31:0] d);
    s_resp = 1'b1; s_rdata = d; tick(); s_resp = 1'b0; s_rdata = '0;
  endtask

  bit          pend [2];
  logic [31:0] rd_data [3] = '{32'hA, 32'hB, 32'hC};

  initial begin
    idle();
    rst = 1'b1;
    m_req[0] = 1'b1; m_req[1] = 1'b1; s_ack = 1'b1; s_resp = 1'b1;
    tick(); tick();
    idle();

    // m1 lone read, response two cycles later
    set_m(1, 1, 0, 32'h100); s_ack = 1'b1; tick();
    set_m(1, 0, 0, 0); s_ack = 1'b0; tick();
    resp(32'hDEAD_BEEF);

    // both masters holding writes
    set_m(0, 1, 1, 32'h40); set_m(1, 1, 1, 32'h80); s_ack = 1'b1;
    repeat (4) tick();
    idle();

    // interleaved reads then in-order responses
    s_ack = 1'b1;
    set_m(0, 1, 0, 32'h10); tick(); set_m(0, 0, 0, 0);
    set_m(1, 1, 0, 32'h20); tick(); set_m(1, 0, 0, 0);
    set_m(0, 1, 0, 32'h30); tick(); set_m(0, 0, 0, 0);
    s_ack = 1'b0;
    for (int j = 0; j < 3; j++) resp(rd_data[j]);

    // fill the read FIFO, then a blocked read alongside a write
    s_ack = 1'b1;
    set_m(0, 1, 0, 32'h200); repeat (4) tick();
    set_m(0, 1, 0, 32'h300); set_m(1, 1, 1, 32'h400); tick();
    set_m(1, 0, 0, 0); tick();
    s_ack = 1'b1; resp(32'h1111_0000); tick();
    set_m(0, 0, 0, 0);
    for (int j = 0; j < 4; j++) resp(32'h2222_0000 + j);

    // spurious response on an idle bus
    rst = 1'b1; tick(); rst = 1'b0;
    resp(32'h3333_3333); repeat (2) tick();

    // reset with reads outstanding, then stale response and fresh arbitration
    s_ack = 1'b1;
    set_m(0, 1, 0, 32'h500); tick(); set_m(0, 0, 0, 0);
    set_m(1, 1, 0, 32'h600); tick(); set_m(1, 0, 0, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    resp(32'h4444_4444);
    set_m(0, 1, 1, 32'h700); set_m(1, 1, 1, 32'h800); tick();
    idle();
    rst = 1'b1; tick(); rst = 1'b0;

    // randomized traffic; masters hold a request until the reference instance acks it
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 79) == 0);
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i]    = 1'b1;
          m_we[i]    = $urandom_range(0, 1) != 0;
          m_addr[i]  = $urandom;
          m_be[i]    = 4'($urandom);
          m_wdata[i] = $urandom;
        end
        m_req[i] = pend[i];
      end
      s_ack   = $urandom_range(0, 3) != 0;
      s_resp  = $urandom_range(0, 2) == 0;
      s_rdata = $urandom;
      tick();
      for (int i = 0; i < 2; i++) if (exp_ack0[i]) pend[i] = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
